// File: rtl/ysyx_22050133_lsu.sv
// Memory-access stage: aligns stores, runs one req/ack bus transaction,
// extends load data and hands a registered result to write-back.
module ysyx_22050133_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic [2:0]  in_funct3,
   input  logic [63:0] in_result,
   input  logic [63:0] in_wdata,
   input  logic [4:0]  in_rd,
   input  logic        in_reg_wen,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_wen,
   output logic [1:0]  out_exc
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        req_q, req_d, we_q, we_d;
   logic [63:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [7:0]  wmask_q, wmask_d;
   logic [2:0]  f3_q, f3_d;
   logic [63:0] res_q, res_d;
   logic        rwen_q, rwen_d, st_q, st_d;
   logic        valid_q, valid_d;
   logic [63:0] data_q, data_d;
   logic [4:0]  rd_q, rd_d;
   logic        owen_q, owen_d;
   logic [1:0]  exc_q, exc_d;

   logic        accept, is_mem, misalign, illegal;
   logic [2:0]  off;
   logic [7:0]  base;
   logic [63:0] raw, ext;

   assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mem   = in_mem_read || in_mem_write;
   assign off      = in_result[2:0];
   assign illegal  = in_mem_write ? in_funct3[2] : (in_funct3 == 3'd7);

   always_comb begin
      misalign = 1'b0;
      base     = 8'h01;
      case (in_funct3[1:0])
         2'd1: begin misalign = off[0];      base = 8'h03; end
         2'd2: begin misalign = |off[1:0];   base = 8'h0F; end
         2'd3: begin misalign = |off;        base = 8'hFF; end
         default: begin misalign = 1'b0;     base = 8'h01; end
      endcase
   end

   assign raw = mem_rdata >> {res_q[2:0], 3'b000};

   always_comb begin
      case (f3_q)
         3'd0:    ext = {{56{raw[7]}},  raw[7:0]};
         3'd1:    ext = {{48{raw[15]}}, raw[15:0]};
         3'd2:    ext = {{32{raw[31]}}, raw[31:0]};
         3'd4:    ext = {56'd0, raw[7:0]};
         3'd5:    ext = {48'd0, raw[15:0]};
         3'd6:    ext = {32'd0, raw[31:0]};
         default: ext = raw;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      f3_d    = f3_q;
      res_d   = res_q;
      rwen_d  = rwen_q;
      st_d    = st_q;
      valid_d = valid_q;
      data_d  = data_q;
      rd_d    = rd_q;
      owen_d  = owen_q;
      exc_d   = exc_q;

      case (state_q)
         WAIT: begin
            if (mem_ack) begin
               req_d   = 1'b0;
               valid_d = 1'b1;
               state_d = DONE;
               data_d  = st_q ? res_q : ext;
               owen_d  = st_q ? 1'b0 : rwen_q;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               req_d   = 1'b0;
               valid_d = 1'b1;
               state_d = DONE;
               data_d  = res_q;
               owen_d  = 1'b0;
               exc_d   = 2'b10;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               valid_d = 1'b0;
               exc_d   = 2'b00;
               state_d = IDLE;
            end
         end
         default: ;
      endcase

      // accept is only possible from IDLE or a draining DONE, so it overrides both
      if (accept) begin
         rd_d    = in_rd;
         f3_d    = in_funct3;
         res_d   = in_result;
         rwen_d  = in_reg_wen;
         st_d    = in_mem_write;
         data_d  = in_result;
         exc_d   = 2'b00;
         if (!is_mem) begin
            owen_d  = in_reg_wen;
            valid_d = 1'b1;
            state_d = DONE;
         end else if (misalign || illegal) begin
            owen_d  = 1'b0;
            exc_d   = 2'b01;
            valid_d = 1'b1;
            state_d = DONE;
         end else begin
            req_d   = 1'b1;
            we_d    = in_mem_write;
            addr_d  = {in_result[63:3], 3'b000};
            wdata_d = in_wdata << {off, 3'b000};
            wmask_d = in_mem_write ? (base << off) : 8'h00;
            cnt_d   = '0;
            owen_d  = 1'b0;
            valid_d = 1'b0;
            state_d = WAIT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         f3_q    <= '0;
         res_q   <= '0;
         rwen_q  <= 1'b0;
         st_q    <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         rd_q    <= '0;
         owen_q  <= 1'b0;
         exc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         f3_q    <= f3_d;
         res_q   <= res_d;
         rwen_q  <= rwen_d;
         st_q    <= st_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         owen_q  <= owen_d;
         exc_q   <= exc_d;
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_rd    = rd_q;
   assign out_wen   = owen_q;
   assign out_exc   = exc_q;

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// Scoreboard bench for the LSU: the bench plays execute stage, data memory
// and write-back; expected results are queued at issue and matched on handshake.
module tb_ysyx_22050133_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_mem_read, in_mem_write;
   logic [2:0]  in_funct3;
   logic [63:0] in_result, in_wdata;
   logic [4:0]  in_rd;
   logic        in_reg_wen;
   logic        mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;
   logic        mem_ack;
   logic        out_valid, out_ready, out_wen;
   logic [63:0] out_data;
   logic [4:0]  out_rd;
   logic [1:0]  out_exc;

   always #5 clk = ~clk;

   ysyx_22050133_lsu #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .in_funct3(in_funct3), .in_result(in_result), .in_wdata(in_wdata),
      .in_rd(in_rd), .in_reg_wen(in_reg_wen),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rd(out_rd), .out_wen(out_wen), .out_exc(out_exc)
   );

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;
   int req_cycles = 0;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  rd;
      logic        wen;
      logic [1:0]  exc;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // write-back side: a handshake happens on the next rising edge
   always @(negedge clk) begin : mon
      exp_t e;
      #2;
      if (rst) begin
         if (mem_req) req_cycles++;
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_out", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("out_data", out_data, e.data);
               check("out_rd",   64'(out_rd),  64'(e.rd));
               check("out_wen",  64'(out_wen), 64'(e.wen));
               check("out_exc",  64'(out_exc), 64'(e.exc));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [63:0] res, input logic [63:0] wd,
                        input logic [4:0] rd, input logic wen,
                        input logic [63:0] ed, input logic ew, input logic [1:0] ee,
                        output int waits);
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1; in_mem_read = mr; in_mem_write = mw; in_funct3 = f3;
      in_result = res; in_wdata = wd; in_rd = rd; in_reg_wen = wen;
      waits = 0;
      #1;
      while (!in_ready && waits < 50) begin
         @(negedge clk); #1;
         waits++;
      end
      if (!in_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
         return;
      end
      e.data = ed; e.rd = rd; e.wen = ew; e.exc = ee;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // memory side: check the held request each cycle, ack after 'delay' cycles
   task automatic serve(input int delay, input logic [63:0] rdata,
                        input logic [63:0] eaddr, input logic ewe,
                        input logic [7:0] emask, input logic [63:0] ewdata);
      for (int i = 1; i <= delay; i++) begin
         @(negedge clk); #3;
         check("mem_req",   64'(mem_req), 64'd1);
         check("mem_addr",  mem_addr, eaddr);
         check("mem_we",    64'(mem_we), 64'(ewe));
         check("mem_wmask", 64'(mem_wmask), 64'(emask));
         check("mem_wdata", mem_wdata, ewdata);
         if (i == 1) check("in_ready_wait", 64'(in_ready), 64'd0);
         if (i == delay) begin
            mem_ack = 1'b1;
            mem_rdata = rdata;
         end
      end
      @(negedge clk); #1;
      mem_ack = 1'b0;
      check("mem_latency_valid", 64'(out_valid), 64'd1);
      check("mem_req_drop", 64'(mem_req), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, h0;
      rst = 1'b0; in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
      in_funct3 = '0; in_result = '0; in_wdata = '0; in_rd = '0; in_reg_wen = 1'b0;
      mem_rdata = '0; mem_ack = 1'b0; out_ready = 1'b1;
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_mem_req",   64'(mem_req), 64'd0);
      check("rst_in_ready",  64'(in_ready), 64'd1);
      check("rst_out_data",  out_data, 64'd0);
      check("rst_out_exc",   64'(out_exc), 64'd0);
      check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
      @(negedge clk); rst = 1'b1;
      // stray ack in IDLE must be ignored
      @(negedge clk); mem_ack = 1'b1;
      @(negedge clk); mem_ack = 1'b0; #3;
      check("idle_ack_ignored", 64'(out_valid), 64'd0);

      // ALU passthrough, then three back-to-back
      issue(1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 5'd5, 1'b1, 64'h1234, 1'b1, 2'd0, w);
      @(negedge clk); #3;
      tick(1);
      h0 = hs_cnt;
      issue(1'b0, 1'b0, 3'd0, 64'hA1, 64'd0, 5'd1, 1'b1, 64'hA1, 1'b1, 2'd0, w);
      check("b2b_wait0", 64'(w), 64'd0);
      issue(1'b0, 1'b0, 3'd0, 64'hB2, 64'd0, 5'd2, 1'b0, 64'hB2, 1'b0, 2'd0, w);
      check("b2b_wait1", 64'(w), 64'd0);
      issue(1'b0, 1'b0, 3'd0, 64'hC3, 64'd0, 5'd3, 1'b1, 64'hC3, 1'b1, 2'd0, w);
      check("b2b_wait2", 64'(w), 64'd0);
      @(negedge clk); #3;
      check("b2b_count", 64'(hs_cnt - h0), 64'd3);
      @(negedge clk); #3;
      check("b2b_idle", 64'(out_valid), 64'd0);

      // SB at offset 3, ack after 3 cycles
      issue(1'b0, 1'b1, 3'd0, 64'h8000_0003, 64'hAB, 5'd9, 1'b1, 64'h8000_0003, 1'b0, 2'd0, w);
      serve(3, 64'd0, 64'h8000_0000, 1'b1, 8'h08, 64'hAB00_0000);
      // SH at offset 2
      issue(1'b0, 1'b1, 3'd1, 64'h40_0002, 64'hBEEF, 5'd9, 1'b0, 64'h40_0002, 1'b0, 2'd0, w);
      serve(1, 64'd0, 64'h40_0000, 1'b1, 8'h0C, 64'hBEEF_0000);
      // SD whose ack lands on the timeout cycle: ack wins
      issue(1'b0, 1'b1, 3'd3, 64'h10, 64'h1122_3344_5566_7788, 5'd4, 1'b1, 64'h10, 1'b0, 2'd0, w);
      serve(4, 64'd0, 64'h10, 1'b1, 8'hFF, 64'h1122_3344_5566_7788);

      // signed/unsigned loads
      issue(1'b1, 1'b0, 3'd1, 64'h8000_0006, 64'd0, 5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 2'd0, w);
      serve(1, 64'h8001_0000_0000_0000, 64'h8000_0000, 1'b0, 8'h00, 64'd0);
      issue(1'b1, 1'b0, 3'd5, 64'h8000_0006, 64'd0, 5'd8, 1'b1, 64'h0000_0000_0000_8001, 1'b1, 2'd0, w);
      serve(2, 64'h8001_0000_0000_0000, 64'h8000_0000, 1'b0, 8'h00, 64'd0);
      issue(1'b1, 1'b0, 3'd0, 64'h8000_0007, 64'd0, 5'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 2'd0, w);
      serve(1, 64'h8001_0000_0000_0000, 64'h8000_0000, 1'b0, 8'h00, 64'd0);
      issue(1'b1, 1'b0, 3'd2, 64'h2C, 64'd0, 5'd11, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF, 1'b1, 2'd0, w);
      serve(1, 64'hDEAD_BEEF_0000_0000, 64'h28, 1'b0, 8'h00, 64'd0);
      issue(1'b1, 1'b0, 3'd6, 64'h2C, 64'd0, 5'd12, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b1, 2'd0, w);
      serve(1, 64'hDEAD_BEEF_0000_0000, 64'h28, 1'b0, 8'h00, 64'd0);
      issue(1'b1, 1'b0, 3'd3, 64'h30, 64'd0, 5'd13, 1'b1, 64'h8765_4321_0FED_CBA9, 1'b1, 2'd0, w);
      serve(2, 64'h8765_4321_0FED_CBA9, 64'h30, 1'b0, 8'h00, 64'd0);

      // misaligned and illegal: never touch the bus
      tick(2);
      req_cycles = 0;
      issue(1'b1, 1'b0, 3'd2, 64'h1002, 64'd0, 5'd14, 1'b1, 64'h1002, 1'b0, 2'd1, w);
      issue(1'b0, 1'b1, 3'd3, 64'h2004, 64'h55, 5'd15, 1'b0, 64'h2004, 1'b0, 2'd1, w);
      issue(1'b1, 1'b0, 3'd7, 64'h3000, 64'd0, 5'd16, 1'b1, 64'h3000, 1'b0, 2'd1, w);
      issue(1'b0, 1'b1, 3'd4, 64'h3008, 64'h66, 5'd17, 1'b0, 64'h3008, 1'b0, 2'd1, w);
      issue(1'b1, 1'b1, 3'd5, 64'h3001, 64'h77, 5'd18, 1'b1, 64'h3001, 1'b0, 2'd1, w);
      tick(3);
      check("exc_no_req", 64'(req_cycles), 64'd0);

      // timeout with write-back backpressure
      out_ready = 1'b0;
      req_cycles = 0;
      issue(1'b1, 1'b0, 3'd3, 64'h2000, 64'd0, 5'd19, 1'b1, 64'h2000, 1'b0, 2'd2, w);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #3;
         check("to_req_high", 64'(mem_req), 64'd1);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #3;
         check("to_req_low",   64'(mem_req), 64'd0);
         check("bp_valid",     64'(out_valid), 64'd1);
         check("bp_exc",       64'(out_exc), 64'd2);
         check("bp_data",      out_data, 64'h2000);
         check("bp_wen",       64'(out_wen), 64'd0);
         check("bp_in_ready",  64'(in_ready), 64'd0);
      end
      check("to_req_cycles", 64'(req_cycles), 64'd4);
      out_ready = 1'b1;
      tick(2); #3;
      check("to_drained", 64'(out_valid), 64'd0);
      check("to_exc_clear", 64'(out_exc), 64'd0);

      // reset while a load waits for its ack
      issue(1'b1, 1'b0, 3'd3, 64'h3000, 64'd0, 5'd20, 1'b1, 64'd0, 1'b1, 2'd0, w);
      @(negedge clk); #3;
      check("rw_req_before", 64'(mem_req), 64'd1);
      rst = 1'b0;
      #1;
      check("rw_req_drop",   64'(mem_req), 64'd0);
      check("rw_valid_drop", 64'(out_valid), 64'd0);
      check("rw_in_ready",   64'(in_ready), 64'd1);
      sb.delete();
      @(negedge clk); rst = 1'b1;
      h0 = hs_cnt;
      @(negedge clk); #1 mem_ack = 1'b1; mem_rdata = 64'hFFFF;
      @(negedge clk); #1 mem_ack = 1'b0;
      tick(3); #3;
      check("rw_late_ack_valid", 64'(out_valid), 64'd0);
      check("rw_late_ack_hs", 64'(hs_cnt - h0), 64'd0);

      tick(2);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
